// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM request arbiter: FSM encoding,
// requester port indices and default address/data widths.
package sdram_arb_pkg;

  localparam int ARB_AW = 27;
  localparam int ARB_DW = 16;

  localparam logic PORT_FSMC = 1'b0;
  localparam logic PORT_AUX  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_WAIT_WR = 2'd3
  } arb_state_e;

  // One-hot select for a requester index; bit 0 is the FSMC port.
  function automatic logic [1:0] port_onehot(input logic port);
    return (port == PORT_AUX) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sdram_req_arbiter_if.sv
// Single-word request/response channel between one requester and the arbiter.
// master = requester side, slave = arbiter side.
interface sdram_req_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int AW = ARB_AW,
  parameter int DW = ARB_DW
) ();

  logic          valid;
  logic          rwn;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          done;

  modport master (
    output valid, rwn, addr, wdata,
    input  ready, rvalid, rdata, done
  );

  modport slave (
    input  valid, rwn, addr, wdata,
    output ready, rvalid, rdata, done
  );

endinterface

// File: rtl/sdram_arb_grant.sv
// Combinational round-robin grant for two requesters; one-hot result, all zero
// when disabled or when nobody is asking.
module sdram_arb_grant
  import sdram_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  input  logic       en,
  output logic [1:0] grant
);

  // A tie goes to the port that did not win the previous accept.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = port_onehot(~last);
        default: grant = 2'b00;
      endcase
    end else begin
      grant = 2'b00;
    end
  end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Two-port round-robin sequencer in front of sdram_controller; one access in flight.
// Optional build macro SDRAM_ARB_WDONE_FALLBACK_EN: end a write when the controller idles without o_write_done.
module sdram_req_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW = ARB_AW,
  parameter int DW = ARB_DW
) (
  input  logic               clk,
  input  logic               nrst,
  sdram_req_arbiter_if.slave req0,
  sdram_req_arbiter_if.slave req1,
  input  logic               ctl_init_done,
  input  logic               ctl_busy,
  input  logic               ctl_ack,
  input  logic               ctl_data_valid,
  input  logic               ctl_write_done,
  input  logic [DW-1:0]      ctl_rdata,
  output logic [AW-1:0]      ctl_addr,
  output logic [DW-1:0]      ctl_wdata,
  output logic               ctl_rwn,
  output logic               ctl_adv
);

  arb_state_e    state_r;
  arb_state_e    state_nxt_s;
  logic          last_r;
  logic          owner_r;
  logic          ctl_idle_s;
  logic          grant_en_s;
  logic [1:0]    valid_s;
  logic [1:0]    grant_s;
  logic          accept_s;
  logic          sel_aux_s;
  logic          rd_cpl_s;
  logic          wr_cpl_s;
  logic          wr_fallback_s;
  logic [1:0]    rvalid_r;
  logic [1:0]    done_r;
  logic [DW-1:0] rdata0_r;
  logic [DW-1:0] rdata1_r;

  assign ctl_idle_s = ctl_init_done & ~ctl_busy;
  assign grant_en_s = (state_r == ST_IDLE) & ctl_idle_s;
  assign valid_s    = {req1.valid, req0.valid};

  sdram_arb_grant u_grant (
    .valid (valid_s),
    .last  (last_r),
    .en    (grant_en_s),
    .grant (grant_s)
  );

  assign req0.ready = grant_s[0];
  assign req1.ready = grant_s[1];
  assign accept_s   = |grant_s;
  assign sel_aux_s  = grant_s[1];

`ifdef SDRAM_ARB_WDONE_FALLBACK_EN
  logic wr_guard_r;

  // Guard is clear on the first WAIT_WR cycle so a just-dropped adv cannot end the write early.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_guard_r <= 1'b0;
    end else begin
      wr_guard_r <= (state_r == ST_WAIT_WR);
    end
  end

  assign wr_fallback_s = wr_guard_r & ctl_idle_s & ~ctl_adv;
`else
  assign wr_fallback_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and completion strobes; a read may finish in ISSUE if data arrives with the ack.
  always_comb begin
    state_nxt_s = state_r;
    rd_cpl_s    = 1'b0;
    wr_cpl_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (ctl_ack && ctl_rwn && ctl_data_valid) begin
          rd_cpl_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (ctl_ack) begin
          state_nxt_s = ctl_rwn ? ST_WAIT_RD : ST_WAIT_WR;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT_RD: begin
        if (ctl_data_valid) begin
          rd_cpl_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_RD;
        end
      end
      ST_WAIT_WR: begin
        if (ctl_write_done || wr_fallback_s) begin
          wr_cpl_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_WR;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Command capture on accept; adv stays up until the controller's ack is sampled.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      ctl_addr  <= '0;
      ctl_wdata <= '0;
      ctl_rwn   <= 1'b0;
      ctl_adv   <= 1'b0;
      owner_r   <= PORT_FSMC;
      last_r    <= PORT_AUX;
    end else if (accept_s) begin
      ctl_addr  <= sel_aux_s ? req1.addr  : req0.addr;
      ctl_wdata <= sel_aux_s ? req1.wdata : req0.wdata;
      ctl_rwn   <= sel_aux_s ? req1.rwn   : req0.rwn;
      ctl_adv   <= 1'b1;
      owner_r   <= sel_aux_s;
      last_r    <= sel_aux_s;
    end else if ((state_r == ST_ISSUE) && ctl_ack) begin
      ctl_adv   <= 1'b0;
    end
  end

  // Completion pulses and read-data hold, routed to the port that owns the access.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rvalid_r <= 2'b00;
      done_r   <= 2'b00;
      rdata0_r <= '0;
      rdata1_r <= '0;
    end else begin
      rvalid_r <= rd_cpl_s ? port_onehot(owner_r) : 2'b00;
      done_r   <= wr_cpl_s ? port_onehot(owner_r) : 2'b00;
      if (rd_cpl_s && (owner_r == PORT_AUX)) begin
        rdata1_r <= ctl_rdata;
      end
      if (rd_cpl_s && (owner_r == PORT_FSMC)) begin
        rdata0_r <= ctl_rdata;
      end
    end
  end

  assign req0.rvalid = rvalid_r[0];
  assign req0.done   = done_r[0];
  assign req0.rdata  = rdata0_r;
  assign req1.rvalid = rvalid_r[1];
  assign req1.done   = done_r[1];
  assign req1.rdata  = rdata1_r;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Scoreboard bench for sdram_req_arbiter: a small controller model answers each adv,
// directed requests push expected issues/responses, a monitor pops and compares.
module tb_sdram_req_arbiter;
  import sdram_arb_pkg::*;

  localparam int AW = 27;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  sdram_req_arbiter_if #(.AW(AW), .DW(DW)) if0 ();
  sdram_req_arbiter_if #(.AW(AW), .DW(DW)) if1 ();

  logic          ctl_init_done, ctl_busy, ctl_ack, ctl_data_valid, ctl_write_done;
  logic [DW-1:0] ctl_rdata;
  logic [AW-1:0] ctl_addr;
  logic [DW-1:0] ctl_wdata;
  logic          ctl_rwn, ctl_adv;
  logic          m_busy, busy_force, drop_wdone;
  int            rd_dly, wr_dly;

  assign ctl_busy = m_busy | busy_force;

  sdram_req_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .req0           (if0.slave),
    .req1           (if1.slave),
    .ctl_init_done  (ctl_init_done),
    .ctl_busy       (ctl_busy),
    .ctl_ack        (ctl_ack),
    .ctl_data_valid (ctl_data_valid),
    .ctl_write_done (ctl_write_done),
    .ctl_rdata      (ctl_rdata),
    .ctl_addr       (ctl_addr),
    .ctl_wdata      (ctl_wdata),
    .ctl_rwn        (ctl_rwn),
    .ctl_adv        (ctl_adv)
  );

  typedef struct { logic is_rd; logic [DW-1:0] data; } resp_t;
  typedef struct { logic [AW-1:0] addr; logic rwn; logic [DW-1:0] wdata; } iss_t;
  resp_t rq0[$];
  resp_t rq1[$];
  iss_t  iq[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic logic [DW-1:0] data_for(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hBFCC;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_iss(input logic [AW-1:0] a, input logic rwn, input logic [DW-1:0] wd);
    iss_t e;
    e.addr = a; e.rwn = rwn; e.wdata = wd;
    iq.push_back(e);
  endtask

  task automatic push_resp(input int p, input logic is_rd, input logic [DW-1:0] d);
    resp_t e;
    e.is_rd = is_rd; e.data = d;
    if (p == 0) rq0.push_back(e); else rq1.push_back(e);
  endtask

  task automatic set_port(input int p, input logic v, input logic rwn, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd);
    if (p == 0) begin
      if0.valid = v; if0.rwn = rwn; if0.addr = a; if0.wdata = wd;
    end else begin
      if1.valid = v; if1.rwn = rwn; if1.addr = a; if1.wdata = wd;
    end
  endtask

  function automatic logic port_ready(input int p);
    return (p == 0) ? if0.ready : if1.ready;
  endfunction

  // Called just after a negedge; holds valid until ready is seen, then releases it.
  task automatic drive_req(input int p, input logic rwn, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd, input bit push);
    bit acc;
    acc = 1'b0;
    set_port(p, 1'b1, rwn, a, wd);
    for (int i = 0; i < 300 && !acc; i++) begin
      #1;
      if (port_ready(p)) begin
        acc = 1'b1;
        if (push) push_resp(p, rwn, exp_rd);
      end
      @(negedge clk);
    end
    set_port(p, 1'b0, rwn, a, wd);
    n_cmp++;
    if (!acc) begin
      n_bad++;
      $display("FAIL accept_timeout port %0d: got no ready, expected accept of addr %h", p, a);
    end
  endtask

  task automatic wait_drain(input string name);
    bit empty;
    empty = 1'b0;
    for (int i = 0; i < 600 && !empty; i++) begin
      if (rq0.size() == 0 && rq1.size() == 0 && iq.size() == 0) empty = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!empty) begin
      n_bad++;
      $display("FAIL %s_drain: got %0d/%0d/%0d pending, expected 0", name, rq0.size(), rq1.size(), iq.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic mon_port(input int p, input logic rv, input logic dn, input logic [DW-1:0] rd);
    resp_t e;
    if (rv || dn) begin
      if ((p == 0 && rq0.size() == 0) || (p == 1 && rq1.size() == 0)) begin
        n_cmp++; n_bad++;
        $display("FAIL resp_unexp port %0d: got rvalid=%0b done=%0b, expected no pulse (t=%0t)", p, rv, dn, $time);
      end else begin
        e = (p == 0) ? rq0.pop_front() : rq1.pop_front();
        check($sformatf("resp_kind_p%0d", p), {30'd0, rv, dn}, {30'd0, e.is_rd, ~e.is_rd});
        if (e.is_rd) check($sformatf("rdata_p%0d", p), 32'(rd), 32'(e.data));
      end
    end
  endtask

  // Controller model: ack the cycle after adv, complete after rd_dly/wr_dly more cycles.
  initial begin
    int            cnt;
    logic          rwn_l;
    logic [AW-1:0] a_l;
    bit            active;
    ctl_ack = 1'b0; ctl_data_valid = 1'b0; ctl_write_done = 1'b0;
    ctl_rdata = '0; m_busy = 1'b0;
    cnt = 0; rwn_l = 1'b0; a_l = '0; active = 1'b0;
    forever begin
      @(negedge clk);
      ctl_ack = 1'b0; ctl_data_valid = 1'b0; ctl_write_done = 1'b0;
      if (!active) begin
        if (ctl_adv === 1'b1) begin
          ctl_ack = 1'b1; m_busy = 1'b1; rwn_l = ctl_rwn; a_l = ctl_addr;
          cnt = rwn_l ? rd_dly : wr_dly; active = 1'b1;
        end
      end else begin
        cnt = cnt - 1;
      end
      if (active && cnt == 0) begin
        if (rwn_l) begin
          ctl_data_valid = 1'b1; ctl_rdata = data_for(a_l);
        end else if (!drop_wdone) begin
          ctl_write_done = 1'b1;
        end
        m_busy = 1'b0; active = 1'b0;
      end
    end
  end

  // Monitor: checks each new command against the issue queue and each pulse against the response queues.
  initial begin
    logic adv_q;
    iss_t e;
    adv_q = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ctl_adv && !adv_q) begin
        if (iq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL issue_unexp: got adv for addr %h, expected none", ctl_addr);
        end else begin
          e = iq.pop_front();
          check("issue_addr", 32'(ctl_addr), 32'(e.addr));
          check("issue_rwn", 32'(ctl_rwn), 32'(e.rwn));
          if (!e.rwn) check("issue_wdata", 32'(ctl_wdata), 32'(e.wdata));
        end
      end
      adv_q = ctl_adv;
      mon_port(0, if0.rvalid, if0.done, if0.rdata);
      mon_port(1, if1.rvalid, if1.done, if1.rdata);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic any_rdy, any_adv;
    nrst = 1'b0; ctl_init_done = 1'b0; busy_force = 1'b0; drop_wdone = 1'b0;
    rd_dly = 2; wr_dly = 3;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_adv", 32'(ctl_adv), 32'd0);
    check("rst_rwn", 32'(ctl_rwn), 32'd0);
    check("rst_addr", 32'(ctl_addr), 32'd0);
    check("rst_wdata", 32'(ctl_wdata), 32'd0);
    check("rst_rdata0", 32'(if0.rdata), 32'd0);
    check("rst_rdata1", 32'(if1.rdata), 32'd0);
    check("rst_pulses", {28'd0, if0.rvalid, if0.done, if1.rvalid, if1.done}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    // Contention from reset: both ports valid while init is pending, then alternate 0,1,0,1,...
    for (int i = 0; i < 4; i++) begin
      push_iss(27'h0000100 + 27'(i), 1'b1, 16'h0);
      push_iss(27'h4000200 + 27'(i), 1'b1, 16'h0);
    end
    fork
      for (int i = 0; i < 4; i++)
        drive_req(0, 1'b1, 27'h0000100 + 27'(i), 16'h0, data_for(27'h0000100 + 27'(i)), 1'b1);
      for (int j = 0; j < 4; j++)
        drive_req(1, 1'b1, 27'h4000200 + 27'(j), 16'h0, data_for(27'h4000200 + 27'(j)), 1'b1);
      begin
        repeat (3) begin
          #1;
          check("init_wait_ready", {30'd0, if1.ready, if0.ready}, 32'd0);
          @(negedge clk);
        end
        ctl_init_done = 1'b1;
      end
    join
    wait_drain("contention");

    // Single read with a 4-cycle data delay.
    rd_dly = 4;
    push_iss(27'h0000123, 1'b1, 16'h0);
    drive_req(0, 1'b1, 27'h0000123, 16'h0, 16'hBEEF, 1'b1);
    wait_drain("single_read");
    repeat (3) @(negedge clk);
    check("rdata0_hold", 32'(if0.rdata), 32'h0000BEEF);

    // Write on the aux port at the top address.
    push_iss(27'h7FFFFFF, 1'b0, 16'h5A5A);
    drive_req(1, 1'b0, 27'h7FFFFFF, 16'h5A5A, 16'h0, 1'b1);
    wait_drain("write");

    // Read data arriving together with the ack, then an immediate follow-up read.
    rd_dly = 0;
    push_iss(27'h0000042, 1'b1, 16'h0);
    push_iss(27'h0000043, 1'b1, 16'h0);
    drive_req(1, 1'b1, 27'h0000042, 16'h0, data_for(27'h0000042), 1'b1);
    drive_req(0, 1'b1, 27'h0000043, 16'h0, data_for(27'h0000043), 1'b1);
    wait_drain("ack_with_data");
    rd_dly = 2;

    // Controller busy for 20 cycles: no ready, no adv; accept on first idle cycle.
    push_iss(27'h0000055, 1'b1, 16'h0);
    busy_force = 1'b1;
    set_port(0, 1'b1, 1'b1, 27'h0000055, 16'h0);
    any_rdy = 1'b0; any_adv = 1'b0;
    repeat (20) begin
      #1;
      any_rdy = any_rdy | if0.ready;
      any_adv = any_adv | ctl_adv;
      @(negedge clk);
    end
    check("busy_ready", 32'(any_rdy), 32'd0);
    check("busy_adv", 32'(any_adv), 32'd0);
    busy_force = 1'b0;
    #1;
    check("busy_release_ready", 32'(if0.ready), 32'd1);
    if (if0.ready) push_resp(0, 1'b1, data_for(27'h0000055));
    @(negedge clk);
    set_port(0, 1'b0, 1'b1, 27'h0000055, 16'h0);
    wait_drain("busy_hold");

    // Controller never pulses write_done but goes idle after its ack.
    drop_wdone = 1'b1; wr_dly = 2;
    push_iss(27'h0000777, 1'b0, 16'h1234);
`ifdef SDRAM_ARB_WDONE_FALLBACK_EN
    drive_req(0, 1'b0, 27'h0000777, 16'h1234, 16'h0, 1'b1);
    wait_drain("fallback_done");
    drop_wdone = 1'b0;
    push_iss(27'h0000888, 1'b1, 16'h0);
    drive_req(1, 1'b1, 27'h0000888, 16'h0, data_for(27'h0000888), 1'b1);
    wait_drain("after_fallback");
`else
    drive_req(0, 1'b0, 27'h0000777, 16'h1234, 16'h0, 1'b0);
    wait_drain("missed_wdone_issue");
    any_rdy = 1'b0;
    set_port(1, 1'b1, 1'b1, 27'h0000888, 16'h0);
    repeat (20) begin
      #1;
      any_rdy = any_rdy | if1.ready;
      @(negedge clk);
    end
    set_port(1, 1'b0, 1'b1, 27'h0000888, 16'h0);
    check("stuck_wait_wr_ready", 32'(any_rdy), 32'd0);
    drop_wdone = 1'b0;
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
`endif
    wr_dly = 3;

    // Reset while waiting for read data: nothing is returned, port 0 wins the next tie.
    rd_dly = 6;
    push_iss(27'h0000999, 1'b1, 16'h0);
    drive_req(0, 1'b1, 27'h0000999, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_adv", 32'(ctl_adv), 32'd0);
    check("midrst_rdata0", 32'(if0.rdata), 32'd0);
    check("midrst_rvalid0", 32'(if0.rvalid), 32'd0);
    nrst = 1'b1;
    repeat (10) @(negedge clk);
    rd_dly = 2;
    push_iss(27'h0000A00, 1'b1, 16'h0);
    push_iss(27'h4000A01, 1'b1, 16'h0);
    fork
      drive_req(0, 1'b1, 27'h0000A00, 16'h0, data_for(27'h0000A00), 1'b1);
      drive_req(1, 1'b1, 27'h4000A01, 16'h0, data_for(27'h4000A01), 1'b1);
    join
    wait_drain("post_reset_tie");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
